// File: rtl/requant_sched.sv
// requant_sched: round-robin scheduler that feeds four request channels
// through one shared requantizer. It reprograms the requantizer only when the
// Nquant value changes, watches for a stalled requantizer, and holds each
// result until the consumer accepts it.
module requant_sched #(
   parameter int unsigned TMO_CYCLES = 63
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  req_valid,
   input  logic [71:0] req_data,
   output logic [3:0]  req_ready,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_ch,
   input  logic [4:0]  cfg_nquant,
   output logic        cfg_err,
   output logic        rq_reset,
   output logic [4:0]  rq_nquant,
   output logic [17:0] rq_datain,
   output logic        rq_endatain,
   input  logic [17:0] rq_dataout,
   input  logic        rq_done,
   output logic        out_valid,
   output logic [17:0] out_data,
   output logic [1:0]  out_ch,
   input  logic        out_ready,
   output logic        busy,
   output logic        timeout_err,
   output logic [15:0] done_cnt
);

   typedef enum logic [2:0] {IDLE, CFG, ISSUE, WAIT, HOLD} state_t;

   localparam logic [5:0] TMO_LAST = 6'(TMO_CYCLES - 1);

   state_t      state;
   logic [1:0]  ptr;
   logic        loaded;
   logic [4:0]  last_nq;
   logic [17:0] cur_data;
   logic [1:0]  cur_ch;
   logic [4:0]  cur_nq;
   logic [5:0]  tmo_cnt;
   logic [4:0]  nq_reg [4];
   logic [17:0] req_word [4];

   logic        gnt_any;
   logic [1:0]  gnt_idx;
   logic [1:0]  cand;
   logic        cfg_ok;

   assign rq_nquant = cur_nq;
   assign rq_datain = cur_data;
   assign cfg_ok    = (cfg_nquant != 5'd0) && (cfg_nquant <= 5'd18);

   // Split the packed request bus into per-channel words.
   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         req_word[i] = req_data[18*i +: 18];
      end
   end

   // Round-robin search starting at ptr for the first valid requester.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         cand = ptr + 2'(i);
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // Grant pulse is only presented when the FSM will actually accept it.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && gnt_any && !reset) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Per-channel Nquant registers; out-of-range writes are rejected with a pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < 4; i++) begin
            nq_reg[i] <= 5'd18;
         end
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         if (cfg_we) begin
            if (cfg_ok) begin
               nq_reg[cfg_ch] <= cfg_nquant;
            end else begin
               cfg_err <= 1'b1;
            end
         end
      end
   end

   // Transaction FSM with registered control outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         loaded      <= 1'b0;
         last_nq     <= '0;
         cur_data    <= '0;
         cur_ch      <= '0;
         cur_nq      <= '0;
         tmo_cnt     <= '0;
         done_cnt    <= '0;
         out_data    <= '0;
         out_ch      <= '0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         rq_reset    <= 1'b0;
         rq_endatain <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         rq_reset    <= 1'b0;
         rq_endatain <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  cur_data <= req_word[gnt_idx];
                  cur_ch   <= gnt_idx;
                  cur_nq   <= nq_reg[gnt_idx];
                  ptr      <= gnt_idx + 2'd1;
                  busy     <= 1'b1;
                  if (!loaded || nq_reg[gnt_idx] != last_nq) begin
                     state    <= CFG;
                     rq_reset <= 1'b1;
                  end else begin
                     state       <= ISSUE;
                     rq_endatain <= 1'b1;
                  end
               end
            end
            CFG: begin
               last_nq     <= cur_nq;
               loaded      <= 1'b1;
               state       <= ISSUE;
               rq_endatain <= 1'b1;
            end
            ISSUE: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               // Compare before incrementing so that rq_done on the same cycle
               // the count would reach TMO_CYCLES still wins.
               if (rq_done) begin
                  out_data  <= rq_dataout;
                  out_ch    <= cur_ch;
                  done_cnt  <= done_cnt + 16'd1;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else if (tmo_cnt == TMO_LAST) begin
                  timeout_err <= 1'b1;
                  loaded      <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 6'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_requant_sched.sv
// tb_requant_sched: directed test of requant_sched with a behavioural
// requantizer responder and hand-computed expected results.
module tb_requant_sched;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [71:0] req_data;
   logic [3:0]  req_ready;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [4:0]  cfg_nquant;
   logic        cfg_err;
   logic        rq_reset;
   logic [4:0]  rq_nquant;
   logic [17:0] rq_datain;
   logic        rq_endatain;
   logic [17:0] rq_dataout;
   logic        rq_done;
   logic        out_valid;
   logic [17:0] out_data;
   logic [1:0]  out_ch;
   logic        out_ready;
   logic        busy;
   logic        timeout_err;
   logic [15:0] done_cnt;

   requant_sched #(.TMO_CYCLES(63)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_nquant(cfg_nquant), .cfg_err(cfg_err),
      .rq_reset(rq_reset), .rq_nquant(rq_nquant), .rq_datain(rq_datain),
      .rq_endatain(rq_endatain), .rq_dataout(rq_dataout), .rq_done(rq_done),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
      .busy(busy), .timeout_err(timeout_err), .done_cnt(done_cnt)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // responder controls
   bit          resp_en = 1'b1;
   bit          resp_fixed = 1'b0;
   int          resp_delay = 1;
   logic [17:0] resp_value = '0;

   // monitor state
   int          cyc = 0;
   int          n_cfg = 0, n_issue = 0, n_tmo = 0, n_cfgerr = 0, n_grant = 0;
   int          issue_cyc = 0, tmo_cyc = 0;
   logic [4:0]  issue_nq = '0;
   logic [17:0] issue_data = '0;
   logic [4:0]  cfg_nq_q [$];
   logic [1:0]  grant_q [$];
   logic [19:0] out_q [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [4:0] val);
      cfg_we = 1'b1;
      cfg_ch = ch;
      cfg_nquant = val;
      tick(1);
      cfg_we = 1'b0;
   endtask

   // Requester: hold valid/data until granted, then drop valid.
   task automatic send(input logic [1:0] ch, input logic [17:0] d);
      bit ok;
      ok = 1'b0;
      req_data[18*int'(ch) +: 18] = d;
      req_valid[ch] = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (req_ready[ch]) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clock);
      #1;
      req_valid[ch] = 1'b0;
      check_val("grant", 32'(ok), 32'd1);
   endtask

   task automatic wait_outs(input int target, input string tag);
      for (int i = 0; i < 300; i++) begin
         if (out_q.size() >= target) break;
         tick(1);
      end
      check_val(tag, 32'(out_q.size()), 32'(target));
      tick(2);
   endtask

   function automatic logic [19:0] last_out();
      if (out_q.size() > 0) return out_q[out_q.size()-1];
      return '1;
   endfunction

   // Behavioural requantizer: answers resp_delay cycles after rq_endatain.
   initial begin
      rq_done = 1'b0;
      rq_dataout = '0;
      forever begin
         @(posedge clock);
         #1;
         if (rq_endatain && resp_en) begin
            repeat (resp_delay) @(posedge clock);
            #1;
            rq_dataout = resp_fixed ? resp_value : (rq_datain ^ {13'd0, rq_nquant});
            rq_done = 1'b1;
            @(posedge clock);
            #1;
            rq_done = 1'b0;
         end
      end
   end

   // Event monitor, sampled on the falling edge.
   always @(negedge clock) begin
      cyc++;
      if (rq_reset) begin
         n_cfg++;
         cfg_nq_q.push_back(rq_nquant);
      end
      if (rq_endatain) begin
         n_issue++;
         issue_cyc = cyc;
         issue_nq = rq_nquant;
         issue_data = rq_datain;
      end
      if (timeout_err) begin
         n_tmo++;
         tmo_cyc = cyc;
      end
      if (cfg_err) n_cfgerr++;
      if (|req_ready) begin
         n_grant++;
         case (req_ready)
            4'b0001: grant_q.push_back(2'd0);
            4'b0010: grant_q.push_back(2'd1);
            4'b0100: grant_q.push_back(2'd2);
            default: grant_q.push_back(2'd3);
         endcase
      end
      if (out_valid && out_ready) out_q.push_back({out_ch, out_data});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int          b_cfg, b_issue, b_tmo, b_err, b_grant, b_outs, gcount;
   logic [15:0] b_done;
   logic [17:0] d [4];
   logic [17:0] hd;
   logic [1:0]  hc;
   logic [19:0] o;
   bit          stable, ok;

   initial begin
      reset = 1'b1;
      req_valid = '0;
      req_data = '0;
      cfg_we = 1'b0;
      cfg_ch = '0;
      cfg_nquant = '0;
      out_ready = 1'b1;
      tick(3);
      reset = 1'b0;

      // reset state
      check_val("rst_ctrl", 32'({busy, out_valid, rq_reset, rq_endatain, cfg_err, timeout_err, req_ready}), 32'd0);
      check_val("rst_out_data", 32'(out_data), 32'd0);
      check_val("rst_out_ch", 32'(out_ch), 32'd0);
      check_val("rst_done_cnt", 32'(done_cnt), 32'd0);

      // first transaction after reset: CFG then ISSUE, fixed result
      resp_fixed = 1'b1;
      resp_value = 18'h00155;
      resp_delay = 5;
      b_cfg = n_cfg; b_issue = n_issue;
      send(2'd0, 18'h2ABCD);
      wait_outs(1, "t1_out");
      o = last_out();
      check_val("t1_cfg", 32'(n_cfg - b_cfg), 32'd1);
      check_val("t1_issue", 32'(n_issue - b_issue), 32'd1);
      check_val("t1_datain", 32'(issue_data), 32'h2ABCD);
      check_val("t1_nq", 32'(issue_nq), 32'd18);
      check_val("t1_data", 32'(o[17:0]), 32'h00155);
      check_val("t1_ch", 32'(o[19:18]), 32'd0);
      check_val("t1_done_cnt", 32'(done_cnt), 32'd1);

      // round-robin with all four requesting; one CFG only
      do_reset();
      resp_fixed = 1'b0;
      resp_delay = 2;
      out_q.delete();
      grant_q.delete();
      b_cfg = n_cfg;
      d[0] = 18'h01111; d[1] = 18'h02222; d[2] = 18'h03333; d[3] = 18'h03C3C;
      req_data = {d[3], d[2], d[1], d[0]};
      req_valid = 4'hF;
      gcount = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (|req_ready) gcount++;
         if (gcount == 5) break;
      end
      @(posedge clock);
      #1;
      req_valid = '0;
      wait_outs(5, "t2_outs");
      for (int k = 0; k < 5; k++) begin
         check_val("t2_grant_order", 32'(grant_q[k]), 32'(k % 4));
         check_val("t2_out_ch", 32'(out_q[k][19:18]), 32'(k % 4));
         check_val("t2_out_data", 32'(out_q[k][17:0]), 32'(d[k % 4] ^ 18'd18));
      end
      check_val("t2_cfg_once", 32'(n_cfg - b_cfg), 32'd1);
      check_val("t2_done_cnt", 32'(done_cnt), 32'd5);

      // per-channel reconfiguration
      b_err = n_cfgerr;
      cfg_write(2'd2, 5'd8);
      cfg_write(2'd3, 5'd12);
      tick(1);
      b_cfg = n_cfg;
      cfg_nq_q.delete();
      out_q.delete();
      send(2'd2, 18'h12345);
      wait_outs(1, "t3_out2");
      check_val("t3_data2", 32'(last_out()), 32'({2'd2, 18'h12345 ^ 18'd8}));
      send(2'd3, 18'h2F0F0);
      wait_outs(2, "t3_out3");
      check_val("t3_data3", 32'(last_out()), 32'({2'd3, 18'h2F0F0 ^ 18'd12}));
      check_val("t3_cfg_cnt", 32'(n_cfg - b_cfg), 32'd2);
      check_val("t3_nq_first", 32'(cfg_nq_q[0]), 32'd8);
      check_val("t3_nq_second", 32'(cfg_nq_q[1]), 32'd12);
      check_val("t3_no_cfg_err", 32'(n_cfgerr - b_err), 32'd0);

      // rejected cfg values, and a cfg write during WAIT
      b_err = n_cfgerr;
      cfg_write(2'd1, 5'd0);
      cfg_write(2'd1, 5'd19);
      tick(2);
      check_val("t4_cfg_err", 32'(n_cfgerr - b_err), 32'd2);
      out_q.delete();
      send(2'd1, 18'h00ABC);
      wait_outs(1, "t4_out_a");
      check_val("t4_nq_kept", 32'(issue_nq), 32'd18);
      check_val("t4_data_a", 32'(last_out()), 32'({2'd1, 18'h00ABC ^ 18'd18}));
      resp_delay = 10;
      send(2'd1, 18'h00F00);
      tick(3);
      cfg_write(2'd1, 5'd5);
      tick(1);
      check_val("t4_wait_nq", 32'(rq_nquant), 32'd18);
      wait_outs(2, "t4_out_b");
      check_val("t4_data_b", 32'(last_out()), 32'({2'd1, 18'h00F00 ^ 18'd18}));
      resp_delay = 2;
      b_cfg = n_cfg;
      send(2'd1, 18'h00F00);
      wait_outs(3, "t4_out_c");
      check_val("t4_new_nq", 32'(issue_nq), 32'd5);
      check_val("t4_new_cfg", 32'(n_cfg - b_cfg), 32'd1);
      check_val("t4_data_c", 32'(last_out()), 32'({2'd1, 18'h00F00 ^ 18'd5}));

      // timeout, then recovery through CFG, then completion on the last WAIT cycle
      resp_en = 1'b0;
      b_tmo = n_tmo; b_done = done_cnt; b_outs = out_q.size();
      send(2'd0, 18'h01234);
      for (int i = 0; i < 200; i++) begin
         if (n_tmo > b_tmo) break;
         tick(1);
      end
      check_val("t5_tmo", 32'(n_tmo - b_tmo), 32'd1);
      check_val("t5_tmo_cycles", 32'(tmo_cyc - issue_cyc), 32'd64);
      check_val("t5_idle", 32'(busy), 32'd0);
      check_val("t5_done_cnt", 32'(done_cnt), 32'(b_done));
      check_val("t5_no_out", 32'(out_q.size()), 32'(b_outs));
      tick(2);
      resp_en = 1'b1;
      resp_delay = 3;
      b_cfg = n_cfg;
      send(2'd0, 18'h01234);
      wait_outs(b_outs + 1, "t5_out_a");
      check_val("t5_recfg", 32'(n_cfg - b_cfg), 32'd1);
      resp_delay = 63;
      b_tmo = n_tmo; b_done = done_cnt;
      send(2'd0, 18'h01234);
      wait_outs(b_outs + 2, "t5_out_b");
      check_val("t5_last_cycle_tmo", 32'(n_tmo - b_tmo), 32'd0);
      check_val("t5_last_cycle_done", 32'(done_cnt), 32'(b_done + 16'd1));
      check_val("t5_last_cycle_data", 32'(last_out()), 32'({2'd0, 18'h01234 ^ 18'd18}));

      // consumer stall in HOLD
      resp_delay = 2;
      out_ready = 1'b0;
      send(2'd3, 18'h3FFFF);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      check_val("t6_out_valid", 32'(ok), 32'd1);
      hd = out_data;
      hc = out_ch;
      b_grant = n_grant;
      req_data[17:0] = 18'h00077;
      req_valid[0] = 1'b1;
      stable = 1'b1;
      repeat (10) begin
         tick(1);
         if (out_data !== hd || out_ch !== hc || out_valid !== 1'b1) stable = 1'b0;
      end
      check_val("t6_stable", 32'(stable), 32'd1);
      check_val("t6_no_grant", 32'(n_grant - b_grant), 32'd0);
      check_val("t6_hold_data", 32'(hd), 32'(18'h3FFFF ^ 18'd12));
      check_val("t6_hold_ch", 32'(hc), 32'd3);
      out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (req_ready[0]) break;
      end
      @(posedge clock);
      #1;
      req_valid[0] = 1'b0;
      check_val("t6_grant_after", 32'(n_grant - b_grant), 32'd1);
      tick(10);

      // reset in the middle of WAIT
      resp_en = 1'b0;
      send(2'd1, 18'h00001);
      tick(4);
      check_val("t7_busy_wait", 32'(busy), 32'd1);
      reset = 1'b1;
      tick(1);
      check_val("t7_rst_ctrl", 32'({busy, out_valid, rq_reset, rq_endatain, cfg_err, timeout_err, req_ready}), 32'd0);
      check_val("t7_rst_out_data", 32'(out_data), 32'd0);
      check_val("t7_rst_out_ch", 32'(out_ch), 32'd0);
      check_val("t7_rst_done_cnt", 32'(done_cnt), 32'd0);
      reset = 1'b0;
      resp_en = 1'b1;
      resp_delay = 1;
      b_cfg = n_cfg;
      b_outs = out_q.size();
      send(2'd1, 18'h00001);
      wait_outs(b_outs + 1, "t7_out");
      check_val("t7_cfg_after_rst", 32'(n_cfg - b_cfg), 32'd1);
      check_val("t7_done_cnt", 32'(done_cnt), 32'd1);
      check_val("t7_data", 32'(last_out()), 32'({2'd1, 18'h00001 ^ 18'd18}));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
